// File: rtl/bp_fe_ras_check.sv
// bp_fe_ras_check: checks RAS return predictions against backend resolution, redirects and restores on a miss
// Define BP_FE_RAS_CHECK_STATS_EN to enable the saturating hit/miss counters.
module bp_fe_ras_check #(
    parameter int eaddr_width_p    = 32,
    parameter int ras_idx_width_p  = 4,
    parameter int pend_idx_width_p = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [eaddr_width_p-1:0]   pred_pc_i,
    input  logic [ras_idx_width_p-1:0] pred_ptr_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic [eaddr_width_p-1:0]   res_pc_i,
    output logic                       res_ready_o,
    output logic                       redirect_v_o,
    output logic [eaddr_width_p-1:0]   redirect_pc_o,
    input  logic                       redirect_yumi_i,
    output logic                       restore_v_o,
    output logic [ras_idx_width_p-1:0] restore_ptr_o,
    output logic [15:0]                hit_cnt_o,
    output logic [15:0]                miss_cnt_o
);
    localparam int depth_lp = 1 << pend_idx_width_p;
    typedef enum logic {IDLE, REDIRECT} state_e;
    state_e                       state_q;
    logic [eaddr_width_p-1:0]     pc_mem_q [depth_lp];
    logic [ras_idx_width_p-1:0]   ptr_mem_q [depth_lp];
    logic [pend_idx_width_p-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [pend_idx_width_p:0]    count_q, count_d;
    logic                         redirect_v_q, restore_v_q;
    logic [eaddr_width_p-1:0]     redirect_pc_q;
    logic [ras_idx_width_p-1:0]   restore_ptr_q;
    logic                         enq, acc, hit, miss;
    assign pred_ready_o  = (state_q == IDLE) & (count_q != (pend_idx_width_p+1)'(depth_lp));
    assign res_ready_o   = (state_q == IDLE) & (count_q != '0);
    assign redirect_v_o  = redirect_v_q;
    assign redirect_pc_o = redirect_pc_q;
    assign restore_v_o   = restore_v_q;
    assign restore_ptr_o = restore_ptr_q;
    // A miss flushes everything: read pointer jumps to the unadvanced write pointer.
    always_comb begin
        enq     = pred_v_i & pred_ready_o;
        acc     = res_v_i & res_ready_o;
        hit     = acc & (res_pc_i == pc_mem_q[rd_q]);
        miss    = acc & ~hit;
        rd_d    = miss ? wr_q : hit ? rd_q + pend_idx_width_p'(1) : rd_q;
        wr_d    = (enq & ~miss) ? wr_q + pend_idx_width_p'(1) : wr_q;
        count_d = miss ? '0
                : (enq & ~hit) ? count_q + (pend_idx_width_p+1)'(1)
                : (hit & ~enq) ? count_q - (pend_idx_width_p+1)'(1)
                : count_q;
    end
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem_q[wr_q]  <= pred_pc_i;
            ptr_mem_q[wr_q] <= pred_ptr_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
            restore_v_q   <= 1'b0;
            restore_ptr_q <= '0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            restore_v_q  <= miss;
            state_q      <= (state_q == IDLE) ? (miss ? REDIRECT : IDLE) : (redirect_yumi_i ? IDLE : REDIRECT);
            redirect_v_q <= (state_q == IDLE) ? miss : ~redirect_yumi_i;
            if (miss) begin
                redirect_pc_q <= res_pc_i;
                restore_ptr_q <= ptr_mem_q[rd_q] - ras_idx_width_p'(1);
            end
        end
    end
`ifdef BP_FE_RAS_CHECK_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 16'd0;
    assign miss_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_bp_fe_ras_check.sv
// tb_bp_fe_ras_check: directed vector table plus hand sequences for full, wrap and reset cases
module tb_bp_fe_ras_check;
    logic        clk_i = 1'b0;
    logic        reset_i, pred_v_i, res_v_i, redirect_yumi_i;
    logic [31:0] pred_pc_i, res_pc_i, redirect_pc_o;
    logic [3:0]  pred_ptr_i, restore_ptr_o;
    logic        pred_ready_o, res_ready_o, redirect_v_o, restore_v_o;
    logic [15:0] hit_cnt_o, miss_cnt_o;
    int checks = 0, failures = 0;
    int m_hit = 0, m_miss = 0;
`ifdef BP_FE_RAS_CHECK_STATS_EN
    localparam logic [15:0] stats_mask = 16'hFFFF;
`else
    localparam logic [15:0] stats_mask = 16'h0000;
`endif
    bp_fe_ras_check dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_pc_i(pred_pc_i), .pred_ptr_i(pred_ptr_i), .pred_ready_o(pred_ready_o),
        .res_v_i(res_v_i), .res_pc_i(res_pc_i), .res_ready_o(res_ready_o),
        .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o), .redirect_yumi_i(redirect_yumi_i),
        .restore_v_o(restore_v_o), .restore_ptr_o(restore_ptr_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic [3:0]  pptr;
        logic        rv;
        logic [31:0] rpc;
        logic        yumi;
        logic        prdy, rrdy, rdv;
        logic [31:0] rdpc;
        logic        rsv;
        logic [3:0]  rsptr;
        logic [15:0] hit, miss;
    } vec_t;
    vec_t vq[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic step(input logic rst, input logic pv, input logic [31:0] ppc, input logic [3:0] pptr,
                        input logic rv, input logic [31:0] rpc, input logic yumi);
        @(negedge clk_i);
        reset_i = rst; pred_v_i = pv; pred_pc_i = ppc; pred_ptr_i = pptr;
        res_v_i = rv; res_pc_i = rpc; redirect_yumi_i = yumi;
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk_core(input string tag, input logic prdy, input logic rrdy, input logic rdv, input logic rsv);
        chk({tag, ".pred_ready"}, 32'(pred_ready_o), 32'(prdy));
        chk({tag, ".res_ready"}, 32'(res_ready_o), 32'(rrdy));
        chk({tag, ".redirect_v"}, 32'(redirect_v_o), 32'(rdv));
        chk({tag, ".restore_v"}, 32'(restore_v_o), 32'(rsv));
        chk({tag, ".hit_cnt"}, 32'(hit_cnt_o), 32'(16'(m_hit) & stats_mask));
        chk({tag, ".miss_cnt"}, 32'(miss_cnt_o), 32'(16'(m_miss) & stats_mask));
    endtask
    task automatic chk_full(input string tag, input vec_t v);
        chk({tag, ".pred_ready"}, 32'(pred_ready_o), 32'(v.prdy));
        chk({tag, ".res_ready"}, 32'(res_ready_o), 32'(v.rrdy));
        chk({tag, ".redirect_v"}, 32'(redirect_v_o), 32'(v.rdv));
        chk({tag, ".redirect_pc"}, redirect_pc_o, v.rdpc);
        chk({tag, ".restore_v"}, 32'(restore_v_o), 32'(v.rsv));
        chk({tag, ".restore_ptr"}, 32'(restore_ptr_o), 32'(v.rsptr));
        chk({tag, ".hit_cnt"}, 32'(hit_cnt_o), 32'(v.hit & stats_mask));
        chk({tag, ".miss_cnt"}, 32'(miss_cnt_o), 32'(v.miss & stats_mask));
    endtask
    initial begin
        vec_t zero_v;
        //                pv ppc       pptr rv rpc       y  prdy rrdy rdv rdpc     rsv rsptr hit miss
        vq.push_back(vec_t'{1, 32'h1004, 3, 0, 0,        0, 1, 1, 0, 32'h0,    0, 4'h0, 0, 0});
        vq.push_back(vec_t'{0, 0,        0, 1, 32'h1004, 0, 1, 0, 0, 32'h0,    0, 4'h0, 1, 0});
        vq.push_back(vec_t'{1, 32'h1004, 3, 0, 0,        0, 1, 1, 0, 32'h0,    0, 4'h0, 1, 0});
        vq.push_back(vec_t'{1, 32'h2008, 2, 0, 0,        0, 1, 1, 0, 32'h0,    0, 4'h0, 1, 0});
        vq.push_back(vec_t'{0, 0,        0, 1, 32'h3000, 0, 0, 0, 1, 32'h3000, 1, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        0, 0, 0, 1, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        0, 0, 0, 1, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        0, 0, 0, 1, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        1, 1, 0, 0, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        1, 1, 0, 0, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{1, 32'h4000, 0, 0, 0,        0, 1, 1, 0, 32'h3000, 0, 4'h2, 1, 1});
        vq.push_back(vec_t'{0, 0,        0, 1, 32'h4004, 0, 0, 0, 1, 32'h4004, 1, 4'hF, 1, 2});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        1, 1, 0, 0, 32'h4004, 0, 4'hF, 1, 2});
        vq.push_back(vec_t'{1, 32'h5000, 5, 0, 0,        0, 1, 1, 0, 32'h4004, 0, 4'hF, 1, 2});
        vq.push_back(vec_t'{1, 32'h6000, 6, 1, 32'h5555, 0, 0, 0, 1, 32'h5555, 1, 4'h4, 1, 3});
        vq.push_back(vec_t'{0, 0,        0, 0, 0,        1, 1, 0, 0, 32'h5555, 0, 4'h4, 1, 3});
        vq.push_back(vec_t'{0, 0,        0, 1, 32'h7777, 0, 1, 0, 0, 32'h5555, 0, 4'h4, 1, 3});
        vq.push_back(vec_t'{1, 32'h7000, 7, 1, 32'h7000, 0, 1, 1, 0, 32'h5555, 0, 4'h4, 1, 3});
        vq.push_back(vec_t'{0, 0,        0, 1, 32'h7000, 0, 1, 0, 0, 32'h5555, 0, 4'h4, 2, 3});
        zero_v = vec_t'{0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 4'h0, 0, 0};
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_full("reset", zero_v);
        foreach (vq[i]) begin
            step(0, vq[i].pv, vq[i].ppc, vq[i].pptr, vq[i].rv, vq[i].rpc, vq[i].yumi);
            chk_full($sformatf("vec%0d", i), vq[i]);
        end
        m_hit = 2; m_miss = 3;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'h100 + 32'(i), 4'(i), 0, 0, 0);
            chk_core($sformatf("fill%0d", i), i != 7, 1, 0, 0);
        end
        step(0, 1, 32'hDEAD, 4'h9, 0, 0, 0);
        chk_core("full_drop", 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, 32'h100 + 32'(i), 0);
            m_hit++;
            chk_core($sformatf("drain%0d", i), 1, i != 7, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 32'h8000 + 32'(4 * i), 4'(i), 0, 0, 0);
            chk_core($sformatf("wrap_enq%0d", i), 1, 1, 0, 0);
            step(0, 0, 0, 0, 1, 32'h8000 + 32'(4 * i), 0);
            m_hit++;
            chk_core($sformatf("wrap_res%0d", i), 1, 0, 0, 0);
        end
        step(0, 1, 32'h9000, 4'h1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h9001, 0);
        m_miss++;
        chk_core("pre_reset", 0, 0, 1, 1);
        chk("pre_reset.restore_ptr", 32'(restore_ptr_o), 32'h0);
        chk("pre_reset.redirect_pc", redirect_pc_o, 32'h9001);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_full("mid_redirect_reset", zero_v);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_full("post_reset_idle", zero_v);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_fe_ras_check.md
Name: bp_fe_ras_check

Overview:
- Resolution-side counterpart of the front-end return address stack (RAS).
- Records every RAS return prediction, together with the stack top-pointer checkpoint taken at prediction time, in an in-order pending queue.
- When the backend resolves each return, compares its actual target against the oldest pending prediction. On a mismatch it issues a front-end redirect, restores the RAS top pointer, and flushes younger wrong-path predictions.

Parameters:
- eaddr_width_p, 32, effective address width.
- ras_idx_width_p, 4, RAS pointer width; must match the RAS instance.
- pend_idx_width_p, 3, pending queue index width; depth = 2**pend_idx_width_p = 8.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- pred_v_i  in  1  RAS issued a valid return prediction this cycle.
- pred_pc_i  in  eaddr_width_p  predicted return target.
- pred_ptr_i  in  ras_idx_width_p  RAS top pointer before the pop.
- pred_ready_o  out  1  queue can accept a prediction.
- res_v_i  in  1  backend resolved a return.
- res_pc_i  in  eaddr_width_p  actual return target.
- res_ready_o  out  1  resolution accepted this cycle.
- redirect_v_o  out  1  front-end redirect request.
- redirect_pc_o  out  eaddr_width_p  redirect target.
- redirect_yumi_i  in  1  redirect consumed.
- restore_v_o  out  1  one-cycle RAS pointer restore strobe.
- restore_ptr_o  out  ras_idx_width_p  corrected RAS top pointer.
- hit_cnt_o  out  16  correct-prediction count (optional feature).
- miss_cnt_o  out  16  misprediction count (optional feature).

Behaviour:
- Reset (synchronous; also aborts a redirect in progress):
  - Queue empty: rd/wr pointers 0, count 0.
  - FSM = IDLE.
  - redirect_v_o=0, redirect_pc_o=0, restore_v_o=0, restore_ptr_o=0, counters 0.
- Queue:
  - Circular buffer of {pc, ptr} entries with a count register of pend_idx_width_p+1 bits; pointers wrap modulo depth.
  - Enqueue fires when pred_v_i & pred_ready_o.
  - pred_ready_o = (state==IDLE) & (count != depth). No enqueue while full, even if a dequeue happens the same cycle.
- Resolution:
  - res_ready_o = (state==IDLE) & (count != 0).
  - res_v_i while res_ready_o=0 is ignored; the backend holds res_v_i until it is accepted.
  - On acceptance, compare res_pc_i with the head entry's pc, full width.
- Match: dequeue head; hit_cnt +1.
- Mismatch, same edge:
  - Flush the whole queue (count=0, rd ptr = wr ptr). A same-cycle enqueue is discarded; flush wins.
  - Latch redirect_pc_o = res_pc_i.
  - Register restore_v_o=1 for exactly one cycle, with restore_ptr_o = head.ptr - 1 modulo 2**ras_idx_width_p. This is the post-pop pointer of the mispredicted return; the decrement wraps 0 -> 2**ras_idx_width_p - 1.
  - miss_cnt +1.
  - Go to REDIRECT.
- FSM:
  - IDLE -> REDIRECT on mismatch.
  - REDIRECT: redirect_v_o=1 and redirect_pc_o held stable until redirect_yumi_i=1. In that cycle redirect_v_o drops on the next edge and the FSM returns to IDLE.
  - redirect_yumi_i in IDLE is ignored.
- Latency:
  - restore_v_o and redirect_v_o both assert the cycle after the mismatching resolution is accepted.
  - Minimum mismatch-to-next-accept is 2 cycles (REDIRECT with immediate yumi, then IDLE).
- Counters are 16-bit and saturate at 16'hFFFF.

Optional Feature:
- Macro: BP_FE_RAS_CHECK_STATS_EN.
- Defined: hit_cnt_o/miss_cnt_o carry the saturating counters described above.
- Undefined: counter registers are not instantiated; hit_cnt_o and miss_cnt_o are tied to 16'd0. All other behaviour is identical.

Test Plan:
- Match: enqueue pc=32'h0000_1004 ptr=4'h3; resolve res_pc=32'h0000_1004 -> res_ready_o=1, queue empty next cycle, no redirect/restore, hit_cnt_o=1 (with macro).
- Mismatch: enqueue pc=32'h1004 ptr=4'h3 then pc=32'h2008 ptr=4'h2; resolve res_pc=32'h3000 -> next cycle restore_v_o=1 for one cycle with restore_ptr_o=4'h2, redirect_v_o=1 with redirect_pc_o=32'h3000, queue empty, pred_ready_o=0; held 3 cycles until yumi, then IDLE with pred_ready_o=1.
- Full: 8 enqueues with no resolution -> pred_ready_o=0; a 9th pred_v_i is dropped; one match dequeue -> pred_ready_o=1 the next cycle.
- Wrap: head ptr=4'h0 mispredicts -> restore_ptr_o=4'hF; 20 back-to-back enqueue/match pairs exercise queue pointer wrap with no loss.
- Simultaneous: mismatch resolution and pred_v_i in the same cycle -> new prediction discarded, count=0; res_v_i with an empty queue -> res_ready_o=0, no state change.
- Reset mid-redirect: assert reset_i while redirect_v_o=1 -> next cycle redirect_v_o=0, IDLE, queue empty, counters 0; without the macro, hit_cnt_o=miss_cnt_o=0 throughout.
